// File: rtl/lc3b_mem_arbiter.sv
// Serializes the core's split instruction/data memory requests onto one physical
// memory port, with a bounded run of data grants before a waiting fetch is forced.
module lc3b_mem_arbiter #(
    parameter int WORD_W    = 16,
    parameter int MASK_W    = 2,
    parameter int MAX_D_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              imem_read,
    input  logic [WORD_W-1:0] imem_address,
    output logic [WORD_W-1:0] imem_rdata,
    output logic              imem_resp,

    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [WORD_W-1:0] dmem_address,
    input  logic [WORD_W-1:0] dmem_wdata,
    input  logic [MASK_W-1:0] dmem_byte_enable,
    output logic [WORD_W-1:0] dmem_rdata,
    output logic              dmem_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [WORD_W-1:0] mem_address,
    output logic [WORD_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_byte_enable,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]        d_run;
    logic [WORD_W-1:0] lat_address;
    logic [WORD_W-1:0] lat_wdata;
    logic [MASK_W-1:0] lat_byte_enable;
    logic              lat_write;
    logic              dreq;
    logic              grant_i;
    logic              grant_d;

    assign dreq    = dmem_read | dmem_write;
    assign grant_i = (state == IDLE) && (next_state == SERVE_I);
    assign grant_d = (state == IDLE) && (next_state == SERVE_D);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Data wins ties until it has taken MAX_D_RUN grants in a row over a waiting fetch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (dreq && imem_read && (d_run == 4'(MAX_D_RUN))) begin
                    next_state = SERVE_I;
                end else if (dreq) begin
                    next_state = SERVE_D;
                end else if (imem_read) begin
                    next_state = SERVE_I;
                end
            end
            SERVE_I,
            SERVE_D: begin
                if (mem_resp) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_run           <= '0;
            lat_address     <= '0;
            lat_wdata       <= '0;
            lat_byte_enable <= '0;
            lat_write       <= 1'b0;
        end else if (grant_d) begin
            lat_address     <= dmem_address;
            lat_wdata       <= dmem_wdata;
            lat_byte_enable <= dmem_write ? dmem_byte_enable : {MASK_W{1'b1}};
            lat_write       <= dmem_write;
            if (!imem_read) begin
                d_run <= '0;
            end else if (d_run != 4'hF) begin
                d_run <= d_run + 4'd1;
            end
        end else if (grant_i) begin
            lat_address     <= imem_address;
            lat_byte_enable <= {MASK_W{1'b1}};
            lat_write       <= 1'b0;
            d_run           <= '0;
        end
    end

    assign mem_address     = lat_address;
    assign mem_wdata       = lat_wdata;
    assign mem_byte_enable = lat_byte_enable;

    // A requester that dropped its request mid-service still finishes at memory, silently.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        imem_resp  = 1'b0;
        dmem_resp  = 1'b0;
        imem_rdata = '0;
        dmem_rdata = '0;
        case (state)
            SERVE_I: begin
                mem_read   = 1'b1;
                imem_resp  = mem_resp & imem_read;
                imem_rdata = mem_rdata;
            end
            SERVE_D: begin
                mem_read   = ~lat_write;
                mem_write  = lat_write;
                dmem_resp  = mem_resp & dreq;
                dmem_rdata = mem_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Directed bench for lc3b_mem_arbiter: a behavioural memory answers the physical port
// while a monitor checks every core response against a queue of expected responses.
module tb_lc3b_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        imem_read;
    logic [15:0] imem_address;
    logic [15:0] imem_rdata;
    logic        imem_resp;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] dmem_rdata;
    logic        dmem_resp;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_rdata;
    logic        mem_resp;

    typedef struct {
        logic        is_d;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vec_count;
    int   miscompares;
    int   mem_latency;
    logic mem_enable;
    logic stray_resp;

    lc3b_mem_arbiter #(
        .WORD_W(16),
        .MASK_W(2),
        .MAX_D_RUN(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_read(imem_read),
        .imem_address(imem_address),
        .imem_rdata(imem_rdata),
        .imem_resp(imem_resp),
        .dmem_read(dmem_read),
        .dmem_write(dmem_write),
        .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata),
        .dmem_byte_enable(dmem_byte_enable),
        .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_address(mem_address),
        .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata),
        .mem_resp(mem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                                 input logic [15:0] da, input logic [15:0] wd, input logic [1:0] be);
        imem_read        = ir;
        imem_address     = ia;
        dmem_read        = dr;
        dmem_write       = dw;
        dmem_address     = da;
        dmem_wdata       = wd;
        dmem_byte_enable = be;
    endtask

    task automatic expectResp(input logic is_d, input logic [15:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Must be called at a negedge; returns at the negedge where the chosen resp is high.
    task automatic waitResp(input logic is_d, input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (is_d ? dmem_resp : imem_resp) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) checkOutput(name, 0, 1);
    endtask

    task automatic nextDrive;
        @(posedge clk);
        #2;
    endtask

    // Memory model: reads return ~address (0x1234 for 0x0010), writes return 0.
    initial begin
        int cnt;
        cnt       = 0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_resp  = stray_resp;
            mem_rdata = '0;
            if (mem_enable && (mem_read || mem_write)) begin
                if (cnt >= mem_latency) begin
                    mem_resp  = 1'b1;
                    mem_rdata = mem_write ? 16'h0000 : (mem_address == 16'h0010) ? 16'h1234 : ~mem_address;
                    cnt       = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (imem_resp || dmem_resp) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_resp", 32'({imem_resp, dmem_resp}), 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("resp_kind", 32'({imem_resp, dmem_resp}), e.is_d ? 'b01 : 'b10);
                    checkOutput("resp_rdata", 32'(dmem_resp ? dmem_rdata : imem_rdata), 32'(e.data));
                    checkOutput("other_rdata", 32'(dmem_resp ? imem_rdata : dmem_rdata), 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int resp_count;
        logic seen;
        vec_count   = 0;
        miscompares = 0;
        mem_latency = 1;
        mem_enable  = 1'b1;
        stray_resp  = 1'b0;
        reset       = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_mem_read", 32'(mem_read), 0);
        checkOutput("rst_mem_write", 32'(mem_write), 0);
        checkOutput("rst_mem_address", 32'(mem_address), 0);
        checkOutput("rst_mem_be", 32'(mem_byte_enable), 0);
        checkOutput("rst_resps", 32'({imem_resp, dmem_resp}), 0);

        $display("[TB] fetch at 0x0010");
        nextDrive();
        mem_latency = 2;
        expectResp(1'b0, 16'h1234);
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        @(negedge clk);
        checkOutput("fetch_idle_cycle", 32'(mem_read), 0);
        @(negedge clk);
        checkOutput("fetch_mem_read", 32'(mem_read), 1);
        checkOutput("fetch_mem_address", 32'(mem_address), 'h0010);
        checkOutput("fetch_mem_write", 32'(mem_write), 0);
        checkOutput("fetch_mem_be", 32'(mem_byte_enable), 'b11);
        waitResp(1'b0, "fetch_resp_timeout");
        nextDrive();
        imem_read = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] store with address change mid-service");
        nextDrive();
        mem_latency = 3;
        expectResp(1'b1, 16'h0000);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 16'h0200, 16'hBEEF, 2'b01);
        @(posedge clk);
        @(negedge clk);
        checkOutput("store_mem_write", 32'(mem_write), 1);
        checkOutput("store_mem_read", 32'(mem_read), 0);
        checkOutput("store_mem_wdata", 32'(mem_wdata), 'hBEEF);
        nextDrive();
        dmem_address     = 16'h0300;
        dmem_wdata       = 16'h1111;
        dmem_byte_enable = 2'b10;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("store_hold_address", 32'(mem_address), 'h0200);
            checkOutput("store_hold_be", 32'(mem_byte_enable), 'b01);
            checkOutput("store_hold_wdata", 32'(mem_wdata), 'hBEEF);
        end
        waitResp(1'b1, "store_resp_timeout");
        nextDrive();
        dmem_write = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] continuous fetch and load");
        nextDrive();
        mem_latency = 1;
        for (int r = 0; r < 2; r++) begin
            repeat (4) expectResp(1'b1, 16'hDFFF);
            expectResp(1'b0, 16'hEFFF);
        end
        applyStimulus(1'b1, 16'h1000, 1'b1, 1'b0, 16'h2000, 16'h0, 2'b00);
        resp_count = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (imem_resp || dmem_resp) resp_count++;
            if (resp_count == 10) break;
        end
        checkOutput("arb_resp_count", 32'(resp_count), 10);
        nextDrive();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        repeat (3) @(negedge clk);

        $display("[TB] flushed load then queued fetch");
        nextDrive();
        mem_latency = 3;
        expectResp(1'b0, 16'h1234);
        applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0400, 16'h0, 2'b00);
        nextDrive();
        dmem_read = 1'b0;
        @(negedge clk);
        checkOutput("flush_mem_read", 32'(mem_read), 1);
        checkOutput("flush_mem_address", 32'(mem_address), 'h0400);
        checkOutput("flush_read_be", 32'(mem_byte_enable), 'b11);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_resp) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("flush_mem_resp_seen", 32'(seen), 1);
        checkOutput("flush_no_dmem_resp", 32'(dmem_resp), 0);
        @(negedge clk);
        checkOutput("flush_idle_gap", 32'(mem_read), 0);
        @(negedge clk);
        checkOutput("flush_fetch_granted", 32'(mem_read), 1);
        checkOutput("flush_fetch_address", 32'(mem_address), 'h0010);
        waitResp(1'b0, "flush_fetch_timeout");
        nextDrive();
        imem_read = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset during store");
        nextDrive();
        mem_enable = 1'b0;
        applyStimulus(1'b1, 16'h0020, 1'b0, 1'b1, 16'h0500, 16'h5555, 2'b11);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstmid_mem_write", 32'(mem_write), 1);
        nextDrive();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstmid_write_dropped", 32'(mem_write), 0);
        checkOutput("rstmid_read_dropped", 32'(mem_read), 0);
        checkOutput("rstmid_d_run", 32'(dut.d_run), 0);
        nextDrive();
        reset = 1'b0;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        nextDrive();
        stray_resp = 1'b1;
        @(negedge clk);
        checkOutput("stray_resp_ignored", 32'({imem_resp, dmem_resp}), 0);
        nextDrive();
        stray_resp = 1'b0;
        @(negedge clk);
        checkOutput("stray_stays_idle", 32'({mem_read, mem_write}), 0);
        mem_enable = 1'b1;

        $display("[TB] read and write together");
        nextDrive();
        mem_latency = 0;
        expectResp(1'b1, 16'h0000);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'h0F0F, 2'b10);
        @(negedge clk);
        @(negedge clk);
        checkOutput("both_mem_write", 32'(mem_write), 1);
        checkOutput("both_mem_read", 32'(mem_read), 0);
        checkOutput("both_mem_address", 32'(mem_address), 'h0040);
        checkOutput("both_mem_be", 32'(mem_byte_enable), 'b10);
        waitResp(1'b1, "both_resp_timeout");
        nextDrive();
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
